// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes, address-width helper and shared typedefs for regfile_mp.
package regfile_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [DEF_XLEN-1:0] xlen_t;
  typedef logic [addr_w(DEF_NREG)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue-over-writeback priority.
// REGFILE_BYPASS_EN selects post-update (defined) or pre-update (undefined) lookups.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_w(DEF_NREG)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_addr_i,
  input  logic [NWR-1:0]  wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]  rd_busy_o
);
  logic [NREG-1:0] busy, busy_nxt;
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++)
      if (wr_en_i[w]) busy_nxt[wr_addr_i[w*AW +: AW]] = 1'b0;
    if (iss_en_i) busy_nxt[iss_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) busy <= '0;
    else busy <= busy_nxt;
`ifdef REGFILE_BYPASS_EN
  always_comb
    for (int p = 0; p < NRD; p++) rd_busy_o[p] = busy_nxt[rd_addr_i[p*AW +: AW]];
`else
  always_comb
    for (int p = 0; p < NRD; p++) rd_busy_o[p] = busy[rd_addr_i[p*AW +: AW]];
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and optional zero register.
// REGFILE_BYPASS_EN forwards same-cycle write data and busy updates to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(NREG)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NRD-1:0]    rd_en_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i
);
  logic [XLEN-1:0] mem [NREG];
  logic [XLEN-1:0] mem_nxt [NREG];
  logic [XLEN-1:0] rd_val [NRD];
  logic [NRD-1:0]  sb_busy;
  // later ports overwrite earlier ones, so the highest-numbered port wins
  always_comb begin
    mem_nxt = mem;
    for (int w = 0; w < NWR; w++)
      if (wr_en_i[w]) mem_nxt[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
    if (ZERO_REG != 0) mem_nxt[0] = '0;
  end
`ifdef REGFILE_BYPASS_EN
  always_comb
    for (int p = 0; p < NRD; p++) rd_val[p] = mem_nxt[rd_addr_i[p*AW +: AW]];
`else
  always_comb
    for (int p = 0; p < NRD; p++) rd_val[p] = mem[rd_addr_i[p*AW +: AW]];
`endif
  regfile_scoreboard #(
    .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_sb (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .iss_en_i(iss_en_i),
    .iss_addr_i(iss_addr_i),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .rd_addr_i(rd_addr_i),
    .rd_busy_o(sb_busy)
  );
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      rd_data_o <= '0;
      rd_busy_o <= '0;
    end else begin
      mem <= mem_nxt;
      for (int p = 0; p < NRD; p++)
        if (rd_en_i[p]) begin
          rd_data_o[p*XLEN +: XLEN] <= rd_val[p];
          rd_busy_o[p] <= sb_busy[p];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with ZERO_REG=1 and ZERO_REG=0 instances.
module tb_regfile_mp;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data, rd_data_z0;
  logic [1:0]  rd_busy, rd_busy_z0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_en = 0;
  logic [4:0]  iss_addr = '0;
  int checks = 0;
  int errors = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr)
  );
  regfile_mp #(.ZERO_REG(0)) dut_z0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_z0), .rd_busy_o(rd_busy_z0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = '0; iss_en = 0;
  endtask

  task automatic rd0(input logic [4:0] a);
    rd_en[0] = 1'b1; rd_addr[4:0] = a;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    wr_en[0] = 1'b1; wr_addr[4:0] = a; wr_data[31:0] = d;
  endtask

  initial begin
    step(); step();
    check("reset_data", rd_data[31:0], 32'h0);
    check("reset_busy", {30'd0, rd_busy}, 32'h0);
    rst_n = 1;
    wr0(5, 32'hDEADBEEF); step(); idle();
    rd0(5); step();
    check("r5_before_reset", rd_data[31:0], 32'hDEADBEEF);
    #2 rst_n = 0;
    #1 check("async_reset_out", rd_data[31:0], 32'h0);
    @(negedge clk) rst_n = 1;
    step();
    check("r5_after_reset", rd_data[31:0], 32'h0);
    check("r5_busy_after_reset", {31'd0, rd_busy[0]}, 32'h0);
    idle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22222222, 32'h11111111};
    step(); idle();
    rd0(7); step();
    check("wr_conflict", rd_data[31:0], 32'h22222222);
    idle();
    wr0(0, 32'hFFFFFFFF); iss_en = 1; iss_addr = 0; step(); idle();
    rd0(0); step();
    check("zero_data", rd_data[31:0], 32'h0);
    check("zero_busy", {31'd0, rd_busy[0]}, 32'h0);
    check("nozero_data", rd_data_z0[31:0], 32'hFFFFFFFF);
    check("nozero_busy", {31'd0, rd_busy_z0[0]}, 32'h1);
    idle();
    wr0(3, 32'hA); step(); idle();
    wr0(3, 32'hB); rd0(3); step(); idle();
    check("same_cycle_rw", rd_data[31:0], BYP ? 32'hB : 32'hA);
    rd0(3); step(); idle();
    check("rw_followup", rd_data[31:0], 32'hB);
    iss_en = 1; iss_addr = 9; step(); idle();
    rd0(9); step(); idle();
    check("issue_busy", {31'd0, rd_busy[0]}, 32'h1);
    wr0(9, 32'h99); step(); idle();
    rd0(9); step(); idle();
    check("write_clears", {31'd0, rd_busy[0]}, 32'h0);
    check("r9_data", rd_data[31:0], 32'h99);
    wr0(9, 32'h98); iss_en = 1; iss_addr = 9; step(); idle();
    rd0(9); step(); idle();
    check("set_wins", {31'd0, rd_busy[0]}, 32'h1);
    wr0(9, 32'h97); step(); idle();
    iss_en = 1; iss_addr = 9; rd0(9); step(); idle();
    check("issue_same_cycle", {31'd0, rd_busy[0]}, BYP ? 32'h1 : 32'h0);
    rd0(9); step(); idle();
    check("issue_followup", {31'd0, rd_busy[0]}, 32'h1);
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3}; step(); idle();
    check("dual_read_p0", rd_data[31:0], 32'hB);
    check("dual_read_p1", rd_data[63:32], 32'hB);
    for (int i = 0; i < 4; i++) begin
      wr0(3, 32'hC0 + i); rd0(3); step(); idle();
      check("hold_p0", rd_data[31:0], BYP ? 32'hC0 + i : (i == 0 ? 32'hB : 32'hC0 + i - 1));
      check("hold_p1", rd_data[63:32], 32'hB);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
